// File: rtl/xbus_pkg.sv
// ---------------------------------------------------------------------------
// xbus_pkg
//
// Purpose:
//   Shared definitions for the xbus link transmitter.
//   - xbus_state_e  : transmitter FSM states (TRAIN, RUN, KALIVE).
//   - XBUS_MIN_SYNC : shortest training burst the receiver can lock onto.
//   - xbus_cnt_width: width of the training burst counter for a burst length.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package xbus_pkg;

  // The receiver needs at least this many sync symbols to find the boundary.
  localparam int XBUS_MIN_SYNC = 8;

  // KALIVE is only reachable when the keep-alive feature is compiled in.
  typedef enum logic [1:0] {
    TRAIN  = 2'd0,
    RUN    = 2'd1,
    KALIVE = 2'd2
  } xbus_state_e;

  // The burst counter must hold the value SYNC_LEN itself and is never
  // narrower than 6 bits so that short bursts share one counter layout.
  function automatic int xbus_cnt_width(input int sync_len);
    int w;
    w = $clog2(sync_len + 1);
    if (w < 6) begin
      w = 6;
    end
    return w;
  endfunction

endpackage

// File: rtl/xbus_sync_tx.sv
// ---------------------------------------------------------------------------
// xbus_sync_tx
//
// Purpose:
//   Link transmitter. After reset (or a retrain request) it sends a training
//   burst of SYNC_LEN sync symbols, then streams upstream words one per cycle.
//   Cycles without a word are filled with sync symbols so the link never
//   goes silent.
//
// Optional feature (macro XBUS_SYNC_TX_KEEPALIVE_EN):
//   Counts accepted beats; every KA_PERIOD beats the transmitter inserts a
//   keep-alive burst (same shape as a training burst) and then resumes.
//   Without the macro the transmitter stays in RUN until retrain or reset.
//
// Parameters:
//   DW        - data width
//   SYNC_LEN  - sync symbols per training / keep-alive burst (>= 8)
//   KA_PERIOD - accepted beats between keep-alive bursts
//
// Ports:
//   clk_i      in   clock, all logic on the rising edge
//   rst_i      in   synchronous active-high reset
//   retrain_i  in   level request to restart training
//   dat_i      in   upstream word
//   valid_i    in   dat_i is valid
//   ready_o    out  dat_i is accepted this cycle (valid_i && ready_o)
//   sync_o     out  registered sync symbol
//   dv_o       out  registered data valid
//   dat_o      out  registered link data
//   training_o out  high while a training or keep-alive burst is running
// ---------------------------------------------------------------------------
module xbus_sync_tx
  import xbus_pkg::*;
#(
  parameter int DW        = 32,
  parameter int SYNC_LEN  = 16,
  parameter int KA_PERIOD = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          retrain_i,
  input  logic [DW-1:0] dat_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          sync_o,
  output logic          dv_o,
  output logic [DW-1:0] dat_o,
  output logic          training_o
);

  localparam int CW = xbus_cnt_width(SYNC_LEN);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN);

  // Refuse to build a transmitter whose bursts the receiver cannot lock onto.
  if (SYNC_LEN < XBUS_MIN_SYNC) begin : g_sync_len_chk
    $error("xbus_sync_tx: SYNC_LEN (%0d) must be at least %0d", SYNC_LEN, XBUS_MIN_SYNC);
  end

  // A keep-alive period of zero beats would never let data through.
  if (KA_PERIOD < 1) begin : g_ka_period_chk
    $error("xbus_sync_tx: KA_PERIOD (%0d) must be at least 1", KA_PERIOD);
  end

  xbus_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;
  logic          dv_q, dv_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          accept;

`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
  localparam int BW = (KA_PERIOD < 2) ? 1 : $clog2(KA_PERIOD + 1);
  localparam logic [BW-1:0] KA_LAST = BW'(KA_PERIOD - 1);

  logic [BW-1:0] beat_q, beat_d;
`endif

  // Upstream handshake: words are only taken in RUN, and a retrain request
  // wins over a pending word so nothing is half-sent into a training burst.
  always_comb begin
    ready_o    = (state_q == RUN) && !retrain_i;
    accept     = valid_i && ready_o;
    training_o = (state_q != RUN);
  end

  // Next-state logic. Every cycle that does not carry an accepted word sends
  // a sync symbol, so training bursts and idle fill look identical on the
  // wire. A burst runs the counter from 0 up to SYNC_LEN: the SYNC_LEN edges
  // that count up produce the burst's sync symbols, and the edge that finds
  // the counter at SYNC_LEN enters RUN while emitting the first idle fill.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = 1'b1;
    dv_d    = 1'b0;
    dat_d   = dat_q;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
    beat_d  = beat_q;
`endif

    case (state_q)
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
      TRAIN, KALIVE: begin
`else
      TRAIN: begin
`endif
        if (retrain_i) begin
          state_d = TRAIN;
          cnt_d   = '0;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
          beat_d  = '0;
`endif
        end else if (cnt_q == SYNC_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
          beat_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RUN: begin
        if (retrain_i) begin
          state_d = TRAIN;
          cnt_d   = '0;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
          beat_d  = '0;
`endif
        end else if (accept) begin
          sync_d = 1'b0;
          dv_d   = 1'b1;
          dat_d  = dat_i;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
          // The beat that completes the period still goes out; the
          // keep-alive burst starts on the following cycle.
          beat_d = beat_q + BW'(1);
          if (beat_q == KA_LAST) begin
            state_d = KALIVE;
            cnt_d   = '0;
          end
`endif
        end
      end

      default: begin
        state_d = TRAIN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers. Reset parks the link silent (no sync, no
  // data) and drops any word in flight; the first edge after reset starts
  // the training burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TRAIN;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      dv_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      dv_q    <= dv_d;
      dat_q   <= dat_d;
    end
  end

`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
  // Accepted-beat counter for keep-alive scheduling. Idle fill leaves it
  // alone; retrain, reset and the end of a keep-alive burst clear it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`endif

  // Drive the link directly from the registers.
  always_comb begin
    sync_o = sync_q;
    dv_o   = dv_q;
    dat_o  = dat_q;
  end

endmodule

// File: tb/tb_xbus_sync_tx.sv
// ---------------------------------------------------------------------------
// tb_xbus_sync_tx
//
// Self-checking bench for xbus_sync_tx (DW=32, SYNC_LEN=16, KA_PERIOD=4).
// The reference model tracks the link as "in RUN or not" plus the number of
// edges left until RUN is reached, and a count of beats since the last
// keep-alive. Keep-alive expectations follow XBUS_SYNC_TX_KEEPALIVE_EN.
// ---------------------------------------------------------------------------
module tb_xbus_sync_tx;

  localparam int DW        = 32;
  localparam int SYNC_LEN  = 16;
  localparam int KA_PERIOD = 4;

  logic          clk;
  logic          rst;
  logic          retrain;
  logic [DW-1:0] datIn;
  logic          validIn;
  logic          readyOut;
  logic          syncOut;
  logic          dvOut;
  logic [DW-1:0] datOut;
  logic          trainingOut;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit            modelValid = 0;
  bit            mInRun     = 0;
  int            mTrainLeft = 0;
  int            mBeats     = 0;
  logic          mSync      = 1'b0;
  logic          mDv        = 1'b0;
  logic [DW-1:0] mDat       = '0;

  // Tracking for the "enough syncs before first data" rule.
  int syncRun       = 0;
  bit sawDvSinceRst = 0;

  typedef struct {
    logic          rst;
    logic          retrain;
    logic          valid;
    logic [DW-1:0] dat;
    logic          eSync;
    logic          eDv;
    logic [DW-1:0] eDat;
    logic          eTrain;
    logic          eReady;
  } vec_t;

  vec_t tbl[$];

  xbus_sync_tx #(
    .DW       (DW),
    .SYNC_LEN (SYNC_LEN),
    .KA_PERIOD(KA_PERIOD)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .retrain_i (retrain),
    .dat_i     (datIn),
    .valid_i   (validIn),
    .ready_o   (readyOut),
    .sync_o    (syncOut),
    .dv_o      (dvOut),
    .dat_o     (datOut),
    .training_o(trainingOut)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic r, input logic rt, input logic v,
                                 input logic [DW-1:0] d, input logic es,
                                 input logic ed, input logic [DW-1:0] edat,
                                 input logic et, input logic er);
    vec_t x;
    x.rst = r; x.retrain = rt; x.valid = v; x.dat = d;
    x.eSync = es; x.eDv = ed; x.eDat = edat; x.eTrain = et; x.eReady = er;
    return x;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the reference model across one rising edge.
  task automatic modelEdge(input logic r, input logic rt, input logic v, input logic [DW-1:0] d);
    if (r) begin
      mInRun = 0; mTrainLeft = SYNC_LEN + 1; mBeats = 0;
      mSync = 1'b0; mDv = 1'b0; mDat = '0;
      modelValid = 1;
    end else if (mInRun && !rt && v) begin
      mSync = 1'b0; mDv = 1'b1; mDat = d;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
      mBeats++;
      if (mBeats == KA_PERIOD) begin
        mInRun = 0; mTrainLeft = SYNC_LEN + 1; mBeats = 0;
      end
`endif
    end else begin
      mSync = 1'b1; mDv = 1'b0;
      if (rt) begin
        mInRun = 0; mTrainLeft = SYNC_LEN + 1; mBeats = 0;
      end else if (!mInRun) begin
        mTrainLeft--;
        if (mTrainLeft == 0) mInRun = 1;
      end
    end
  endtask

  // Compare DUT outputs with the model after an edge, plus global invariants.
  task automatic checkOutput();
    check("sync", {31'b0, syncOut}, {31'b0, mSync});
    check("dv", {31'b0, dvOut}, {31'b0, mDv});
    check("dat", datOut, mDat);
    check("training", {31'b0, trainingOut}, {31'b0, !mInRun});
    check("ready", {31'b0, readyOut}, {31'b0, mInRun && !retrain});
    check("syncDvExcl", {31'b0, syncOut && dvOut}, 32'd0);
    if (rst) begin
      syncRun = 0; sawDvSinceRst = 0;
    end else begin
      if (dvOut && !sawDvSinceRst) begin
        check("syncBeforeFirstDv", {31'b0, syncRun >= 8}, 32'd1);
        sawDvSinceRst = 1;
      end
      syncRun = syncOut ? syncRun + 1 : 0;
    end
  endtask

  // Drive one cycle of inputs (called at the falling edge), check the
  // combinational ready, clock the DUT and model, then check the outputs.
  task automatic applyStimulus(input logic r, input logic rt, input logic v,
                               input logic [DW-1:0] d, output logic acc);
    rst = r; retrain = rt; validIn = v; datIn = d;
    #1;
    acc = readyOut && v;
    if (modelValid) begin
      check("readyPre", {31'b0, readyOut}, {31'b0, mInRun && !rt});
    end
    modelEdge(r, rt, v, d);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic acc;
    int n;
    int sCnt;
    logic [DW-1:0] got[$];
    int issued;
    int lowCycles;
    int cyc;

    rst = 1'b1; retrain = 1'b0; validIn = 1'b0; datIn = '0;
    @(negedge clk);

    // Reset, full training burst, four back-to-back beats, then idle fill.
    tbl.push_back(mkVec(1, 0, 0, '0, 0, 0, '0, 1, 0));
    for (int i = 1; i <= SYNC_LEN; i++) begin
      tbl.push_back(mkVec(0, 0, 0, '0, 1, 0, '0, 1, 0));
    end
    tbl.push_back(mkVec(0, 0, 0, '0, 1, 0, '0, 0, 1));
    for (int b = 1; b <= 4; b++) begin
      logic [DW-1:0] w;
      w = 32'h11 * b;
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
      if (b == 4) tbl.push_back(mkVec(0, 0, 1, w, 0, 1, w, 1, 0));
      else        tbl.push_back(mkVec(0, 0, 1, w, 0, 1, w, 0, 1));
`else
      tbl.push_back(mkVec(0, 0, 1, w, 0, 1, w, 0, 1));
`endif
    end
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
    tbl.push_back(mkVec(0, 0, 0, '0, 1, 0, 32'h44, 1, 0));
`else
    tbl.push_back(mkVec(0, 0, 0, '0, 1, 0, 32'h44, 0, 1));
`endif

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].retrain, tbl[i].valid, tbl[i].dat, acc);
      check($sformatf("tbl%0d.sync", i), {31'b0, syncOut}, {31'b0, tbl[i].eSync});
      check($sformatf("tbl%0d.dv", i), {31'b0, dvOut}, {31'b0, tbl[i].eDv});
      check($sformatf("tbl%0d.dat", i), datOut, tbl[i].eDat);
      check($sformatf("tbl%0d.training", i), {31'b0, trainingOut}, {31'b0, tbl[i].eTrain});
      check($sformatf("tbl%0d.ready", i), {31'b0, readyOut}, {31'b0, tbl[i].eReady});
    end

    // Get back to RUN (a keep-alive burst may be running).
    n = 0;
    while (!readyOut && n < 40) begin
      applyStimulus(0, 0, 0, '0, acc); n++;
    end
    check("reachRun", {31'b0, readyOut}, 32'd1);

    // Retrain pulse with a word offered: word refused, full burst follows.
    applyStimulus(0, 1, 1, 32'hDEADBEEF, acc);
    check("retrainAccepted", {31'b0, acc}, 32'd0);
    check("retrainNoBeat", {31'b0, dvOut}, 32'd0);
    n = 0; sCnt = 0;
    while (!readyOut && n < 40) begin
      applyStimulus(0, 0, 0, '0, acc); n++;
      if (syncOut) sCnt++;
    end
    check("retrainReadyGap", n, SYNC_LEN + 1);
    check("retrainSyncs", {31'b0, sCnt >= SYNC_LEN}, 32'd1);

    // Reset ten cycles into a training burst.
    applyStimulus(0, 1, 0, '0, acc);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, '0, acc);
    applyStimulus(1, 0, 0, '0, acc);
    check("midRstSync", {31'b0, syncOut}, 32'd0);
    check("midRstDv", {31'b0, dvOut}, 32'd0);
    check("midRstDat", datOut, 32'd0);
    check("midRstTraining", {31'b0, trainingOut}, 32'd1);
    check("midRstReady", {31'b0, readyOut}, 32'd0);
    n = 0; sCnt = 0;
    while (trainingOut && n < 40) begin
      applyStimulus(0, 0, 0, '0, acc); n++;
      if (syncOut && trainingOut) sCnt++;
    end
    check("rstBurstLen", sCnt, SYNC_LEN);

    // Stream ten words with valid held high; order must survive any bursts.
    got.delete(); issued = 0; lowCycles = 0; cyc = 0;
    while (issued < 10 && cyc < 300) begin
      applyStimulus(0, 0, 1, 32'h100 + issued, acc);
      if (acc) issued++;
      else lowCycles++;
      if (dvOut) got.push_back(datOut);
      cyc++;
    end
    check("streamCount", got.size(), 10);
    foreach (got[i]) check($sformatf("streamOrder%0d", i), got[i], 32'h100 + i);
`ifdef XBUS_SYNC_TX_KEEPALIVE_EN
    check("kaGapCycles", lowCycles, 2 * (SYNC_LEN + 1));
`else
    check("noGapCycles", lowCycles, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 999);
      applyStimulus(r < 4, (r >= 4) && (r < 20), $urandom_range(0, 3) != 0, $urandom, acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_sync_tx.md
XBUS_SYNC_TX -- requirements
Module: xbus_sync_tx

Interface
REQ-001 SHALL have parameter DW, default 32, transmit data width in bits.
REQ-002 SHALL have parameter SYNC_LEN, default 16, sync cycles per training burst; elaboration SHALL fail if SYNC_LEN < 8.
REQ-003 SHALL have parameter KA_PERIOD, default 1024, data beats between keep-alive bursts; used only under the macro in REQ-026.
REQ-004 SHALL have port clk_i, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port retrain_i, input, 1, level request to restart training.
REQ-007 SHALL have port dat_i, input, DW, word offered by upstream.
REQ-008 SHALL have port valid_i, input, 1, dat_i is valid.
REQ-009 SHALL have port ready_o, output, 1, block accepts dat_i this cycle.
REQ-010 SHALL have port sync_o, output, 1, registered sync symbol to the link.
REQ-011 SHALL have port dv_o, output, 1, registered data-valid to the link.
REQ-012 SHALL have port dat_o, output, DW, registered link data.
REQ-013 SHALL have port training_o, output, 1, high while a training or keep-alive burst is in progress.

Function
REQ-014 SHALL implement states TRAIN, RUN, KALIVE (KALIVE exists only with the REQ-026 macro).
REQ-015 In TRAIN: sync_o=1, dv_o=0, ready_o=0, and a 6-bit-minimum burst counter increments each cycle.
REQ-016 TRAIN SHALL emit exactly SYNC_LEN consecutive sync_o=1 cycles, then enter RUN with training_o=0 on the same edge.
REQ-017 ready_o SHALL equal (state==RUN) && !retrain_i (combinational); a beat is accepted when valid_i && ready_o.
REQ-018 An accepted beat SHALL appear on the next cycle as dat_o=dat_i, dv_o=1, sync_o=0 (latency 1).
REQ-019 In RUN with no accepted beat, the next cycle SHALL be idle fill: sync_o=1, dv_o=0, dat_o held.
REQ-020 sync_o and dv_o SHALL never be high in the same cycle.
REQ-021 retrain_i high in RUN SHALL move to TRAIN with the counter cleared; no beat is accepted that cycle.
REQ-022 retrain_i high in TRAIN or KALIVE SHALL clear the counter, restarting the full SYNC_LEN burst.
REQ-023 Back-to-back beats SHALL sustain one word per cycle with no inserted idle.

Reset
REQ-024 While rst_i=1 at a clock edge: state=TRAIN, counter=0, sync_o=0, dv_o=0, dat_o=0, training_o=1, ready_o=0.
REQ-025 The first edge with rst_i=0 SHALL set sync_o=1; reset asserted mid-burst or mid-data SHALL abandon it immediately, with no partial word completed.

Configuration
REQ-026 Macro XBUS_SYNC_TX_KEEPALIVE_EN: when defined, a beat counter SHALL count accepted beats; when it reaches KA_PERIOD, RUN SHALL enter KALIVE, which behaves as TRAIN (SYNC_LEN syncs, ready_o=0, training_o=1), then returns to RUN with the beat counter cleared.
REQ-027 Idle-fill cycles SHALL NOT clear the beat counter; retrain and reset SHALL clear it.
REQ-028 When undefined: no beat counter, no KALIVE state; RUN persists until retrain_i or rst_i.

Structure
REQ-029 Shared package xbus_pkg SHALL hold the state enum (TRAIN, RUN, KALIVE) and constant XBUS_MIN_SYNC=8 used by the REQ-002 check.
REQ-030 No sub-module; burst counter, beat counter and FSM are in one module.

Verification
REQ-031 Release reset, hold valid_i=0 -> sync_o=1 for exactly 16 cycles, training_o falls and ready_o rises on the 17th cycle, sync_o stays 1 (idle fill).
REQ-032 In RUN, drive 4 consecutive beats 0x11..0x44 -> dv_o=1 with dat_o=0x11,0x22,0x33,0x44 on the following 4 cycles, sync_o=0 throughout.
REQ-033 Pulse retrain_i for 1 cycle while valid_i=1 -> that beat is not accepted, ready_o=0, and 16 sync cycles follow before ready_o returns.
REQ-034 Assert rst_i for 1 cycle at training count 10 -> all outputs go to reset values and a full 16-cycle burst restarts.
REQ-035 With XBUS_SYNC_TX_KEEPALIVE_EN and KA_PERIOD=4, stream 10 beats -> a 16-cycle sync burst follows beats 4 and 8, with data order preserved.
REQ-036 Every scenario: assert sync_o and dv_o are never both 1, and sync_o=1 for at least 8 cycles before the first dv_o=1.
